// File: rtl/iref_seq.sv
// iref_seq: power-up / settle / charge / refresh sequencer for the
// current-reference macro, with a 4-word CPU register file.
// Ports: clk, rst (async, active-high); CPU bus valid/address/wdata/wstrb
// -> rdata/ready (registered, one-cycle ack); macro controls pd, charge;
// status ref_ok to analog consumers; irq (reference-valid interrupt).
// Optional feature macro: IREF_SEQ_IRQ_EN enables the irq_flag / irq path.
// Registers: 0 CTRL{refresh_en,enable}, 1 CHARGE_LEN[15:0],
// 2 REFRESH_PER[23:0], 3 STATUS{irq_flag,state[1:0],ref_ok} (write clears flag).
module iref_seq #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              pd,
  output logic              charge,
  output logic              ref_ok,
  output logic              irq
);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    CHARGE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [23:0] SETTLE_LD = 24'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [23:0]       cnt_q, cnt_d;
  logic              arm_q, arm_d;
  logic [1:0]        ctrl_q;
  logic [15:0]       len_q;
  logic [23:0]       per_q;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q, rd_d;
  logic              pd_q, charge_q, ref_ok_q;
  logic              flag_rd;
  logic              acc, wr, rd;
  logic              cnt_zero;
  logic [23:0]       len_ld;
  logic [1:0]        sel;
  logic              unused_wdata;

  // A request is taken only while no ack is pending, so a
  // held valid is never accepted twice.
  assign acc = valid && !ready_q;
  assign wr  = acc && wstrb;
  assign rd  = acc && !wstrb;
  assign sel = address[1:0];

  assign unused_wdata = ^wdata[DATA_W-1:24];

  assign cnt_zero = (cnt_q == 24'd0);
  assign len_ld   = (len_q == 16'd0) ? 24'd0
                                     : {8'd0, len_q - 16'd1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= 2'd0;
      len_q   <= 16'd16;
      per_q   <= 24'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= acc;
      if (wr) begin
        case (sel)
          2'd0:    ctrl_q <= wdata[1:0];
          2'd1:    len_q  <= wdata[15:0];
          2'd2:    per_q  <= wdata[23:0];
          default: ;
        endcase
      end
      if (rd) rdata_q <= rd_d;
    end
  end

  always_comb begin
    rd_d = '0;
    case (sel)
      2'd0:    rd_d[1:0]  = ctrl_q;
      2'd1:    rd_d[15:0] = len_q;
      2'd2:    rd_d[23:0] = per_q;
      default: rd_d[3:0]  = {flag_rd, state_q, ref_ok_q};
    endcase
  end

  // Clearing enable overrides any counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    if (!ctrl_q[0]) begin
      state_d = OFF;
      cnt_d   = '0;
      arm_d   = 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end
        SETTLE: begin
          if (cnt_zero) begin
            state_d = CHARGE;
            cnt_d   = len_ld;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        CHARGE: begin
          if (cnt_zero) begin
            state_d = HOLD;
            arm_d   = ctrl_q[1] && (per_q != 24'd0);
            cnt_d   = arm_d ? per_q - 24'd1 : 24'd0;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        HOLD: begin
          // arm_q records whether refresh was set up on entry
          if (arm_q) begin
            if (!cnt_zero) begin
              cnt_d = cnt_q - 24'd1;
            end else if (ctrl_q[1]) begin
              state_d = CHARGE;
              cnt_d   = len_ld;
            end else begin
              arm_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      arm_q    <= 1'b0;
      pd_q     <= 1'b1;
      charge_q <= 1'b0;
      ref_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
      pd_q     <= (state_d == OFF);
      charge_q <= (state_d == CHARGE);
      // refresh CHARGE keeps ref_ok; only OFF drops it
      ref_ok_q <= (state_d == HOLD) ||
                  ((state_d == CHARGE) && ref_ok_q);
    end
  end

`ifdef IREF_SEQ_IRQ_EN
  logic flag_q, flag_set, flag_clr;

  // first HOLD entry after enable is the only one with ref_ok low
  assign flag_set = (state_d == HOLD) && !ref_ok_q;
  assign flag_clr = wr && (sel == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_q <= 1'b0;
    else if (flag_set) flag_q <= 1'b1;
    else if (flag_clr) flag_q <= 1'b0;
  end

  assign flag_rd = flag_q;
`else
  assign flag_rd = 1'b0;
`endif

  assign irq    = flag_rd;
  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign pd     = pd_q;
  assign charge = charge_q;
  assign ref_ok = ref_ok_q;

endmodule

// File: tb/tb_iref_seq.sv
// tb_iref_seq: self-checking bench for iref_seq.
// Event-time reference model, register table, directed and random sequences.
module tb_iref_seq;

  localparam int S     = 64;
  localparam int NEVER = 32'h7fffffff;
`ifdef IREF_SEQ_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  address;
  logic [31:0] wdata;
  logic        wstrb;
  logic [31:0] rdata;
  logic        ready, pd, charge, ref_ok, irq;

  always #5 clk = ~clk;

  iref_seq #(
    .ADDR_W(2),
    .DATA_W(32),
    .SETTLE_CYC(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .address(address),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .pd(pd),
    .charge(charge),
    .ref_ok(ref_ok),
    .irq(irq)
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // reference model: register copies plus absolute event times
  bit          m_en, m_ren, m_on, m_chg, m_ok, m_flag, m_ready;
  int          m_len, m_per;
  logic [31:0] m_rdata;
  int          rise, fall;

  // observers
  int  rises[$];
  int  falls[$];
  int  t_pd0;
  bit  prev_chg;
  bit  mon_ok;
  int  ok_drops;
  int  wcyc;

  typedef struct {
    bit          wr;
    bit [1:0]    a;
    bit [31:0]   d;
    bit [31:0]   exp;
    string       nm;
  } vec_t;

  function automatic bit [1:0] mcode();
    if (!m_on) return 2'd0;
    if (m_chg) return 2'd2;
    if (m_ok) return 2'd3;
    return 2'd1;
  endfunction

  task automatic model_reset();
    m_en = 0; m_ren = 0; m_on = 0; m_chg = 0; m_ok = 0;
    m_flag = 0; m_ready = 0; m_rdata = '0;
    m_len = 16; m_per = 0;
    rise = NEVER; fall = NEVER;
  endtask

  task automatic model_edge(input bit v, input bit [1:0] a,
                            input bit [31:0] d, input bit w);
    bit acc;
    bit set;
    acc = v && !m_ready;
    set = 1'b0;
    if (acc && !w) begin
      case (a)
        2'd0:    m_rdata = {30'd0, m_ren, m_en};
        2'd1:    m_rdata = m_len;
        2'd2:    m_rdata = m_per;
        default: m_rdata = {28'd0, m_flag, mcode(), m_ok};
      endcase
    end
    if (!m_en) begin
      m_on = 0; m_chg = 0; m_ok = 0;
      rise = NEVER; fall = NEVER;
    end else if (!m_on) begin
      m_on = 1;
      rise = cyc + S;
    end else if (cyc == rise) begin
      rise = NEVER;
      if (!(m_ok && !m_ren)) begin
        m_chg = 1;
        fall = cyc + ((m_len == 0) ? 1 : m_len);
      end
    end else if (cyc == fall) begin
      fall = NEVER;
      m_chg = 0;
      set = !m_ok;
      m_ok = 1;
      if (m_ren && m_per != 0) rise = cyc + m_per;
    end
    if (IRQ) begin
      if (set) m_flag = 1;
      else if (acc && w && a == 2'd3) m_flag = 0;
    end
    if (acc && w) begin
      case (a)
        2'd0:    begin m_en = d[0]; m_ren = d[1]; end
        2'd1:    m_len = d[15:0];
        2'd2:    m_per = d[23:0];
        default: ;
      endcase
    end
    m_ready = acc;
  endtask

  task automatic tick(input bit v, input bit [1:0] a,
                      input bit [31:0] d, input bit w);
    valid = v; address = a; wdata = d; wstrb = w;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_edge(v, a, d, w);
    @(negedge clk);
    ntests++;
    if (ready !== m_ready || rdata !== m_rdata || pd !== !m_on ||
        charge !== m_chg || ref_ok !== m_ok || irq !== m_flag) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL cycle %0d: got rdy=%b rd=%h pd=%b chg=%b ok=%b irq=%b want rdy=%b rd=%h pd=%b chg=%b ok=%b irq=%b",
                 cyc, ready, rdata, pd, charge, ref_ok, irq,
                 m_ready, m_rdata, !m_on, m_chg, m_ok, m_flag);
    end
    if (charge && !prev_chg) rises.push_back(cyc);
    if (!charge && prev_chg) falls.push_back(cyc);
    prev_chg = charge;
    if (!pd && t_pd0 < 0) t_pd0 = cyc;
    if (mon_ok && !ref_ok) ok_drops++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'd0, 32'd0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic bus_wr(input bit [1:0] a, input bit [31:0] d);
    tick(1, a, d, 1);
    wcyc = cyc;
    tick(0, 2'd0, 32'd0, 0);
  endtask

  task automatic bus_rd(input bit [1:0] a, input bit [31:0] exp,
                        input string nm);
    tick(1, a, 32'd0, 0);
    chk(nm, rdata, exp);
    tick(0, 2'd0, 32'd0, 0);
  endtask

  task automatic clear_obs();
    rises.delete();
    falls.delete();
    t_pd0 = -1;
    ok_drops = 0;
    mon_ok = 0;
  endtask

  task automatic wait_q(input bit use_falls, input int n,
                        input int bound, input string nm);
    int i;
    i = 0;
    while ((use_falls ? falls.size() : rises.size()) < n && i < bound) begin
      tick(0, 2'd0, 32'd0, 0);
      i++;
    end
    ntests++;
    if ((use_falls ? falls.size() : rises.size()) < n) begin
      nfail++;
      $display("FAIL %s: timeout after %0d cycles", nm, bound);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  vec_t vt[12];

  initial begin
    vt[0]  = '{0, 2'd0, 32'h0,        32'h0,      "rst_ctrl"};
    vt[1]  = '{0, 2'd1, 32'h0,        32'h10,     "rst_len"};
    vt[2]  = '{0, 2'd2, 32'h0,        32'h0,      "rst_per"};
    vt[3]  = '{0, 2'd3, 32'h0,        32'h0,      "rst_status"};
    vt[4]  = '{1, 2'd0, 32'h2,        32'h2,      "ctrl_ren"};
    vt[5]  = '{1, 2'd0, 32'hFFFFFFFE, 32'h2,      "ctrl_mask"};
    vt[6]  = '{1, 2'd0, 32'h0,        32'h0,      "ctrl_zero"};
    vt[7]  = '{1, 2'd1, 32'hABCD1234, 32'h1234,   "len_mask"};
    vt[8]  = '{1, 2'd1, 32'h0,        32'h0,      "len_zero"};
    vt[9]  = '{1, 2'd2, 32'hFF123456, 32'h123456, "per_mask"};
    vt[10] = '{1, 2'd2, 32'h0,        32'h0,      "per_zero"};
    vt[11] = '{1, 2'd3, 32'hFFFFFFFF, 32'h0,      "status_ro"};

    valid = 0; address = 0; wdata = 0; wstrb = 0;
    prev_chg = 0;
    clear_obs();
    model_reset();
    rst = 0;
    #1 rst = 1;
    #1;
    chk("rst_pd", {31'd0, pd}, 32'd1);
    chk("rst_outs", {ready, charge, ref_ok, irq}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    idle(2);
    rst = 0;
    idle(3);

    // register table
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) bus_wr(vt[i].a, vt[i].d);
      bus_rd(vt[i].a, vt[i].exp, vt[i].nm);
    end

    // basic sequence, CHARGE_LEN=10
    bus_wr(2'd1, 32'd10);
    clear_obs();
    bus_wr(2'd0, 32'd1);
    wait_q(1, 1, 300, "seqA_wait");
    chk("seqA_pd_lat", t_pd0 - wcyc, 1);
    chk("seqA_rise_lat", qat(rises, 0) - wcyc, S + 1);
    chk("seqA_width", qat(falls, 0) - qat(rises, 0), 10);
    chk("seqA_ref_ok", {31'd0, ref_ok}, 32'd1);
    chk("seqA_irq", {31'd0, irq}, {31'd0, IRQ});
    bus_rd(2'd3, IRQ ? 32'hF : 32'h7, "seqA_status");

    // CHARGE_LEN=0 gives a single-cycle pulse
    bus_wr(2'd0, 32'd0);
    bus_wr(2'd3, 32'd0);
    bus_wr(2'd1, 32'd0);
    clear_obs();
    bus_wr(2'd0, 32'd1);
    wait_q(1, 1, 300, "len0_wait");
    chk("len0_width", qat(falls, 0) - qat(rises, 0), 1);
    chk("len0_rise_lat", qat(rises, 0) - wcyc, S + 1);

    // refresh: PER=100, LEN=10
    bus_wr(2'd0, 32'd0);
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd2, 32'd100);
    clear_obs();
    bus_wr(2'd0, 32'd3);
    wait_q(1, 1, 300, "ref_first");
    mon_ok = 1;
    bus_wr(2'd3, 32'd0);
    chk("ref_irq_clr", {31'd0, irq}, 32'd0);
    wait_q(0, 3, 500, "ref_rises");
    chk("ref_gap", qat(rises, 1) - qat(falls, 0), 100);
    chk("ref_period", qat(rises, 2) - qat(rises, 1), 110);
    chk("ref_ok_drops", ok_drops, 0);
    chk("ref_irq_quiet", {31'd0, irq}, 32'd0);

    // disable during refresh CHARGE
    mon_ok = 0;
    chk("dis_in_charge", {31'd0, charge}, 32'd1);
    bus_wr(2'd0, 32'd0);
    chk("dis_outs", {29'd0, pd, charge, ref_ok}, 32'h4);
    bus_rd(2'd3, 32'h0, "dis_status");
    bus_wr(2'd2, 32'd0);
    clear_obs();
    bus_wr(2'd0, 32'd1);
    wait_q(1, 1, 300, "reen_wait");
    chk("reen_rise_lat", qat(rises, 0) - wcyc, S + 1);

    // async reset mid-HOLD
    idle(3);
    chk("pre_rst_ok", {31'd0, ref_ok}, 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_outs",
        {27'd0, ready, pd, charge, ref_ok, irq}, 32'h8);
    chk("arst_rdata", rdata, 32'd0);
    idle(2);
    rst = 0;
    clear_obs();
    idle(100);
    chk("post_rst_off", t_pd0, -1);
    bus_rd(2'd0, 32'h0, "post_rst_ctrl");
    bus_rd(2'd1, 32'h10, "post_rst_len");

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit [31:0] d;
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 60) begin
        idle(1);
      end else if (r < 70) begin
        tick(1, 2'($urandom_range(0, 3)), d, 0);
        idle(1);
      end else if (r < 73) begin
        d[0] = ($urandom_range(0, 7) != 0);
        bus_wr(2'd0, d);
      end else if (r < 85) begin
        d[15:0] = 16'($urandom_range(0, 5));
        bus_wr(2'd1, d);
      end else if (r < 95) begin
        d[23:0] = 24'($urandom_range(0, 8));
        bus_wr(2'd2, d);
      end else begin
        bus_wr(2'd3, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
